buffer_arbiter: RTL

Sequencing controller for the 64-byte USB endpoint data buffer. It owns every strobe into the buffer and grants access to one requester at a time: the host-side register interface (fill TX bytes, drain RX bytes) or the USB protocol side (RX packet writer, TX packet reader). It tracks buffer ownership through a packet-level state machine, issues `clear` and `flush`, and rejects out-of-phase or overflowing requests with error pulses. It sits between the AHB slave / USB RX / USB TX controllers and `buffer`.

---
 rtl/usb_pkg.sv | 16 +
 rtl/buffer_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB endpoint definitions: buffer geometry and the buffer arbiter state encoding.
package usb_pkg;

    localparam int BUF_DEPTH = 64;
    localparam int BUF_OCC_W = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RX_ACTIVE = 3'd1,
        S_RX_HELD   = 3'd2,
        S_TX_FILL   = 3'd3,
        S_TX_ACTIVE = 3'd4,
        S_CLEARING  = 3'd5
    } buf_state_t;

endpackage

// File: rtl/buffer_arbiter.sv
// Sequencing controller for the 64-byte endpoint buffer. Grants one requester per
// cycle (host register side or USB RX/TX side), owns every buffer strobe, and
// tracks packet-level ownership of the buffer through a single FSM.
module buffer_arbiter
    import usb_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int OCC_W = BUF_OCC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_wr_req,
    input  logic [7:0]       host_wr_data,
    input  logic             host_rd_req,
    input  logic             host_clear,
    input  logic             rx_start,
    input  logic             rx_byte_valid,
    input  logic [7:0]       rx_byte,
    input  logic             rx_done,
    input  logic             rx_error,
    input  logic             tx_start,
    input  logic             tx_byte_req,
    input  logic [OCC_W-1:0] buff_occ,
    output logic             store_tx_data,
    output logic             store_rx_data,
    output logic             get_tx_data,
    output logic             get_rx_data,
    output logic             clear,
    output logic             flush,
    output logic [7:0]       tx_data,
    output logic [7:0]       RX_packet_data,
    output logic             host_wr_ack,
    output logic             host_rd_ack,
    output logic             rx_byte_ack,
    output logic             tx_byte_ack,
    output logic             host_err,
    output logic             rx_overflow,
    output logic             rx_packet_ready,
    output logic             tx_busy,
    output logic [2:0]       state
);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    buf_state_t       cur_state;
    logic [OCC_W-1:0] occ_eff;

    // Occupancy the buffer will hold once the strobe currently on the wires lands;
    // buff_occ itself lags our strobes by one cycle, so back-to-back grants use this.
    always_comb begin
        occ_eff = buff_occ;
        if (clear || flush)
            occ_eff = '0;
        else if (store_tx_data || store_rx_data)
            occ_eff = buff_occ + OCC_ONE;
        else if (get_tx_data || get_rx_data)
            occ_eff = buff_occ - OCC_ONE;
    end

    // Packet-level ownership FSM; every strobe and error pulse is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state      <= S_IDLE;
            store_tx_data  <= 1'b0;
            store_rx_data  <= 1'b0;
            get_tx_data    <= 1'b0;
            get_rx_data    <= 1'b0;
            clear          <= 1'b0;
            flush          <= 1'b0;
            host_err       <= 1'b0;
            rx_overflow    <= 1'b0;
            tx_data        <= 8'h00;
            RX_packet_data <= 8'h00;
        end else begin
            store_tx_data <= 1'b0;
            store_rx_data <= 1'b0;
            get_tx_data   <= 1'b0;
            get_rx_data   <= 1'b0;
            clear         <= 1'b0;
            flush         <= 1'b0;
            host_err      <= 1'b0;
            rx_overflow   <= 1'b0;

            case (cur_state)
                S_IDLE: begin
                    host_err <= host_rd_req;
                    if (host_clear) begin
                        cur_state <= S_CLEARING;
                        clear     <= 1'b1;
                    end else if (rx_start) begin
                        cur_state <= S_RX_ACTIVE;
                    end else if (host_wr_req) begin
                        cur_state     <= S_TX_FILL;
                        store_tx_data <= 1'b1;
                        tx_data       <= host_wr_data;
                    end
                end

                S_RX_ACTIVE: begin
                    host_err <= host_wr_req | host_rd_req;
                    if (rx_error) begin
                        cur_state <= S_IDLE;
                        flush     <= 1'b1;
                    end else begin
                        if (rx_byte_valid) begin
                            if (occ_eff < OCC_FULL) begin
                                store_rx_data  <= 1'b1;
                                RX_packet_data <= rx_byte;
                            end else begin
                                rx_overflow <= 1'b1;
                            end
                        end
                        if (rx_done)
                            cur_state <= S_RX_HELD;
                    end
                end

                S_RX_HELD: begin
                    host_err <= host_wr_req;
                    if (host_clear) begin
                        cur_state <= S_CLEARING;
                        clear     <= 1'b1;
                    end else if (host_rd_req) begin
                        if (occ_eff != '0) begin
                            get_rx_data <= 1'b1;
                            if (occ_eff == OCC_ONE)
                                cur_state <= S_IDLE;
                        end else begin
                            host_err <= 1'b1;
                        end
                    end
                end

                S_TX_FILL: begin
                    host_err <= host_rd_req;
                    if (host_clear) begin
                        cur_state <= S_CLEARING;
                        clear     <= 1'b1;
                    end else if (tx_start) begin
                        cur_state <= S_TX_ACTIVE;
                        host_err  <= host_wr_req | host_rd_req;
                    end else if (host_wr_req) begin
                        if (occ_eff < OCC_FULL) begin
                            store_tx_data <= 1'b1;
                            tx_data       <= host_wr_data;
                        end else begin
                            host_err <= 1'b1;
                        end
                    end
                end

                S_TX_ACTIVE: begin
                    host_err <= host_wr_req | host_rd_req;
                    if (tx_byte_req && (occ_eff != '0))
                        get_tx_data <= 1'b1;
                    else if (occ_eff == '0)
                        cur_state <= S_IDLE;
                end

                S_CLEARING: begin
                    host_err  <= host_wr_req | host_rd_req;
                    cur_state <= S_IDLE;
                end

                default: cur_state <= S_IDLE;
            endcase
        end
    end

    assign host_wr_ack     = store_tx_data;
    assign rx_byte_ack     = store_rx_data;
    assign host_rd_ack     = get_rx_data;
    assign tx_byte_ack     = get_tx_data;
    assign rx_packet_ready = (cur_state == S_RX_HELD);
    assign tx_busy         = (cur_state == S_TX_ACTIVE);
    assign state           = cur_state;

endmodule
